// File: rtl/line_req_sched.sv
// line_req_sched: schedules 512-bit line transfers from i-fill, d-fill and
// writeback requesters onto a single bus-arbiter line port, one at a time.
module line_req_sched #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned ADDR_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [511:0]      i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [511:0]      d_rdata,
    output logic              d_done,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [511:0]      wb_wdata,
    output logic              wb_done,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [511:0]      m_wdata,
    input  logic [511:0]      m_rdata,
    input  logic              m_done,
    output logic [1:0]        grant
);

    localparam int unsigned LINE_W = 512;
    localparam int unsigned OFF_W  = 6;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_I    = 2'd1;
    localparam logic [1:0] G_D    = 2'd2;
    localparam logic [1:0] G_WB   = 2'd3;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                m_req_q, m_req_d;
    logic                m_wr_q, m_wr_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [LINE_W-1:0]   m_wdata_q, m_wdata_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [1:0]          grant_q, grant_d;
    logic                i_done_q, i_done_d;
    logic                d_done_q, d_done_d;
    logic                wb_done_q, wb_done_d;
    logic [CNT_W-1:0]    starve_q, starve_d;

    logic                hazard_c;
    logic [1:0]          win_c;
    logic [ADDR_W-1:0]   sel_addr_c;

    // Winner selection: RAW hazard first, then starved I, then D, WB, I.
    always_comb begin
        hazard_c   = d_req && wb_req &&
                     (d_addr[ADDR_W-1:OFF_W] == wb_addr[ADDR_W-1:OFF_W]);
        win_c      = G_NONE;
        sel_addr_c = '0;
        if (hazard_c) begin
            win_c = G_WB;
        end else if (i_req && (starve_q >= CNT_W'(STARVE_LIMIT))) begin
            win_c = G_I;
        end else if (d_req) begin
            win_c = G_D;
        end else if (wb_req) begin
            win_c = G_WB;
        end else if (i_req) begin
            win_c = G_I;
        end
        case (win_c)
            G_I:     sel_addr_c = i_addr;
            G_D:     sel_addr_c = d_addr;
            G_WB:    sel_addr_c = wb_addr;
            default: sel_addr_c = '0;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_wr_d    = m_wr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        line_d    = line_q;
        grant_d   = grant_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        wb_done_d = 1'b0;
        starve_d  = starve_q;

        if (!i_req) begin
            starve_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (win_c != G_NONE) begin
                    m_req_d   = 1'b1;
                    grant_d   = win_c;
                    m_wr_d    = (win_c == G_WB);
                    m_addr_d  = sel_addr_c & LINE_MASK;
                    m_wdata_d = (win_c == G_WB) ? wb_wdata : '0;
                    state_d   = BUSY;
                    if (win_c == G_I) begin
                        starve_d = '0;
                    end else if (i_req && (starve_q != CNT_MAX)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (m_done) begin
                    m_req_d = 1'b0;
                    if (grant_q != G_WB) begin
                        line_d = m_rdata;
                    end
                    i_done_d  = (grant_q == G_I);
                    d_done_d  = (grant_q == G_D);
                    wb_done_d = (grant_q == G_WB);
                    state_d   = RESP;
                end
            end
            RESP: begin
                grant_d = G_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            line_q    <= '0;
            grant_q   <= G_NONE;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            wb_done_q <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            line_q    <= line_d;
            grant_q   <= grant_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            wb_done_q <= wb_done_d;
            starve_q  <= starve_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_wr    = m_wr_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign grant   = grant_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign wb_done = wb_done_q;
    assign i_rdata = line_q;
    assign d_rdata = line_q;

endmodule
